// File: rtl/hs_mem_sdpram_fifo.sv
// hs_mem_sdpram_fifo: single-clock FIFO built on a 1W/1R RAM (read latency 1)
// with a 3-entry register output buffer that hides the read latency and
// sustains one item per cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clr               synchronous flush (priority over everything)
//   s_data/valid/ready  write stream
//   m_data/valid/ready  read stream (m_data is the head of the output buffer)
//   level             total occupancy: RAM + read in flight + output buffer
//
// hs_mem_sdpram: simple dual-port RAM, registered read, no reset.
//   clk, i_wen/i_waddr/i_wdata write port, i_ren/i_raddr read port, o_rdata.

module hs_mem_sdpram #(
  parameter type         DATA_TYPE  = logic [7:0],
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  DATA_TYPE              i_wdata,
  input  logic                  i_ren,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output DATA_TYPE              o_rdata
);

  localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;

  DATA_TYPE r_mem [NUM_WORDS];

  // Storage array and registered read port
  always_ff @(posedge clk) begin
    if (i_wen) r_mem[i_waddr] <= i_wdata;
    if (i_ren) o_rdata <= r_mem[i_raddr];
  end

endmodule

module hs_mem_sdpram_fifo #(
  parameter type         DATA_TYPE  = logic [7:0],
  parameter int unsigned DATA_DEPTH = 16,
  localparam int unsigned LVL_WIDTH = $clog2(DATA_DEPTH + 4)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  DATA_TYPE             s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output DATA_TYPE             m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [LVL_WIDTH-1:0] level
);

  localparam int unsigned AW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int unsigned CW = $clog2(DATA_DEPTH + 1);
  localparam int unsigned OB_DEPTH = 3;

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_ram_cnt;
  logic          r_inflight;
  logic [1:0]    r_ob_cnt;
  DATA_TYPE      r_ob [OB_DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_ren;
  logic [1:0]    w_cap_idx;
  logic [AW-1:0] w_wptr_nxt;
  logic [AW-1:0] w_rptr_nxt;
  DATA_TYPE      w_rdata;

  // Handshakes and read issue; the current pop is intentionally not credited
  always_comb begin
    s_ready = (r_ram_cnt < CW'(DATA_DEPTH)) & ~clr;
    m_valid = (r_ob_cnt != 2'd0) & ~clr;
    w_push  = s_valid & s_ready;
    w_pop   = m_valid & m_ready;
    w_ren   = (r_ram_cnt != CW'(0))
            & ((3'(r_ob_cnt) + 3'(r_inflight)) < 3'd3)
            & ~clr;
  end

  // Pointer wrap for non-power-of-two depths
  always_comb begin
    w_wptr_nxt = (r_wptr == AW'(DATA_DEPTH - 1)) ? '0 : r_wptr + AW'(1);
    w_rptr_nxt = (r_rptr == AW'(DATA_DEPTH - 1)) ? '0 : r_rptr + AW'(1);
  end

  // Returning data lands behind the entries that survive this cycle's pop
  assign w_cap_idx = r_ob_cnt - 2'(w_pop);

  assign m_data = r_ob[0];
  assign level  = LVL_WIDTH'(r_ram_cnt) + LVL_WIDTH'(r_inflight)
                + LVL_WIDTH'(r_ob_cnt);

  hs_mem_sdpram #(
    .DATA_TYPE  (DATA_TYPE),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk     (clk),
    .i_wen   (w_push),
    .i_waddr (r_wptr),
    .i_wdata (s_data),
    .i_ren   (w_ren),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  // Pointers, RAM occupancy and in-flight flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
    end else if (clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_ren)  r_rptr <= w_rptr_nxt;
      case ({w_push, w_ren})
        2'b10:   r_ram_cnt <= r_ram_cnt + CW'(1);
        2'b01:   r_ram_cnt <= r_ram_cnt - CW'(1);
        default: r_ram_cnt <= r_ram_cnt;
      endcase
      r_inflight <= w_ren;
    end
  end

  // Output buffer occupancy; capture and pop together leave it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ob_cnt <= 2'd0;
    end else if (clr) begin
      r_ob_cnt <= 2'd0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10:   r_ob_cnt <= r_ob_cnt + 2'd1;
        2'b01:   r_ob_cnt <= r_ob_cnt - 2'd1;
        default: r_ob_cnt <= r_ob_cnt;
      endcase
    end
  end

  // Output buffer data: shift on pop, then write the captured word
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_ob[0] <= r_ob[1];
      r_ob[1] <= r_ob[2];
    end
    if (r_inflight && !clr) begin
      for (int unsigned i = 0; i < OB_DEPTH; i++) begin
        if (w_cap_idx == 2'(i)) r_ob[i] <= w_rdata;
      end
    end
  end

endmodule

// File: tb/tb_hs_mem_sdpram_fifo.sv
// tb_hs_mem_sdpram_fifo: self-checking bench for hs_mem_sdpram_fifo.
// Two instances (depth 16 and depth 5) are checked against a queue model:
// accepted items are appended, popped items must match the queue head, and
// the reported level must equal accepted-minus-popped.

module tb_hs_mem_sdpram_fifo;

  logic       clk;
  logic       rst;

  logic       clr16, sv16, sr16, mv16, mr16;
  logic [7:0] sd16, md16;
  logic [4:0] lv16;

  logic       clr5, sv5, sr5, mv5, mr5;
  logic [7:0] sd5, md5;
  logic [3:0] lv5;

  int n_checks;
  int n_errors;

  logic [7:0] q16[$];
  logic [7:0] q5[$];

  // Last sampled values from the cycle tasks
  logic o16_sr, o16_mv, o16_acc, o16_pop;
  int   o16_lv;
  logic [7:0] o16_md;
  logic o5_sr, o5_mv, o5_acc, o5_pop;
  int   o5_lv;

  hs_mem_sdpram_fifo #(.DATA_DEPTH(16)) u_dut16 (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr16),
    .s_data  (sd16),
    .s_valid (sv16),
    .s_ready (sr16),
    .m_data  (md16),
    .m_valid (mv16),
    .m_ready (mr16),
    .level   (lv16)
  );

  hs_mem_sdpram_fifo #(.DATA_DEPTH(5)) u_dut5 (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr5),
    .s_data  (sd5),
    .s_valid (sv5),
    .s_ready (sr5),
    .m_data  (md5),
    .m_valid (mv5),
    .m_ready (mr5),
    .level   (lv5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle on the depth-16 instance: drive, sample at negedge, score, advance
  task automatic cyc16(input logic sv, input logic [7:0] d, input logic mr, input logic cl);
    sv16 = sv; sd16 = d; mr16 = mr; clr16 = cl;
    @(negedge clk);
    o16_sr = sr16; o16_mv = mv16; o16_lv = int'(lv16); o16_md = md16;
    check("lvl16", 32'(lv16), 32'(q16.size()));
    if (cl) begin
      check("clr_sready16", 32'(sr16), 32'd0);
      check("clr_mvalid16", 32'(mv16), 32'd0);
    end
    o16_acc = sv & sr16;
    o16_pop = mv16 & mr;
    if (o16_pop) begin
      check("pop_nonempty16", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) begin
        check("data16", 32'(md16), 32'(q16[0]));
        void'(q16.pop_front());
      end
    end
    if (o16_acc) q16.push_back(d);
    @(posedge clk);
    if (cl) q16.delete();
    #2;
  endtask

  // Same for the depth-5 instance
  task automatic cyc5(input logic sv, input logic [7:0] d, input logic mr, input logic cl);
    sv5 = sv; sd5 = d; mr5 = mr; clr5 = cl;
    @(negedge clk);
    o5_sr = sr5; o5_mv = mv5; o5_lv = int'(lv5);
    check("lvl5", 32'(lv5), 32'(q5.size()));
    check("lvl5_max", 32'(lv5 <= 4'd8), 32'd1);
    o5_acc = sv & sr5;
    o5_pop = mv5 & mr;
    if (o5_pop) begin
      check("pop_nonempty5", 32'(q5.size() != 0), 32'd1);
      if (q5.size() != 0) begin
        check("data5", 32'(md5), 32'(q5[0]));
        void'(q5.pop_front());
      end
    end
    if (o5_acc) q5.push_back(d);
    @(posedge clk);
    if (cl) q5.delete();
    #2;
  endtask

  initial begin
    int first_pop, last_pop, n_pop, n_acc, cyc;
    logic seen;

    n_checks = 0; n_errors = 0;
    rst = 1'b1;
    clr16 = 0; sv16 = 0; mr16 = 0; sd16 = '0;
    clr5  = 0; sv5  = 0; mr5  = 0; sd5  = '0;
    #12 rst = 1'b0;
    #1;
    check("rst_sready16", 32'(sr16), 32'd1);
    check("rst_mvalid16", 32'(mv16), 32'd0);
    check("rst_level16",  32'(lv16), 32'd0);
    check("rst_sready5",  32'(sr5),  32'd1);
    @(posedge clk); #2;

    // Latency: single item into empty FIFO, consumer ready
    cyc16(1'b1, 8'hA5, 1'b1, 1'b0);
    cyc16(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_c1_mv", 32'(o16_mv), 32'd0);
    check("lat_c1_lv", 32'(o16_lv), 32'd1);
    cyc16(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_c2_mv", 32'(o16_mv), 32'd0);
    check("lat_c2_lv", 32'(o16_lv), 32'd1);
    cyc16(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_c3_mv", 32'(o16_mv), 32'd1);
    check("lat_c3_md", 32'(o16_md), 32'hA5);
    check("lat_c3_lv", 32'(o16_lv), 32'd1);
    cyc16(1'b0, 8'h00, 1'b1, 1'b0);
    check("lat_c4_lv", 32'(o16_lv), 32'd0);

    // Streaming 0..255 back-to-back
    first_pop = -1; last_pop = -1; n_pop = 0;
    for (int i = 0; i < 300; i++) begin
      cyc16(i < 256, 8'(i), 1'b1, 1'b0);
      if (i < 256) check("stream_acc", 32'(o16_acc), 32'd1);
      check("stream_lvl_le3", 32'(o16_lv <= 3), 32'd1);
      if (o16_pop) begin
        if (first_pop < 0) first_pop = i;
        last_pop = i;
        n_pop++;
      end
    end
    check("stream_npop", 32'(n_pop), 32'd256);
    check("stream_first", 32'(first_pop), 32'd3);
    check("stream_span", 32'(last_pop - first_pop), 32'd255);

    // Mid-stream asynchronous reset
    for (int i = 0; i < 4; i++) cyc16(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc5(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    sv16 = 0; mr16 = 0; sv5 = 0; mr5 = 0;
    #1 rst = 1'b1;
    #1;
    check("midrst_sready16", 32'(sr16), 32'd1);
    check("midrst_mvalid16", 32'(mv16), 32'd0);
    check("midrst_level16",  32'(lv16), 32'd0);
    check("midrst_level5",   32'(lv5),  32'd0);
    q16.delete(); q5.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;

    // Full, depth 5: exactly 8 accepted with no consumer
    n_acc = 0;
    for (int i = 0; i < 14; i++) begin
      cyc5(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      if (o5_acc) n_acc++;
    end
    check("full_nacc", 32'(n_acc), 32'd8);
    cyc5(1'b0, 8'h00, 1'b0, 1'b0);
    check("full_sready", 32'(o5_sr), 32'd0);
    check("full_level", 32'(o5_lv), 32'd8);
    cyc5(1'b0, 8'h00, 1'b1, 1'b0);
    check("full_pop", 32'(o5_pop), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc5(1'b0, 8'h00, 1'b0, 1'b0);
      if (o5_sr) seen = 1'b1;
    end
    check("full_sready_back", 32'(seen), 32'd1);
    for (int i = 0; i < 40 && q5.size() != 0; i++) cyc5(1'b0, 8'h00, 1'b1, 1'b0);
    check("full_drained", 32'(q5.size()), 32'd0);

    // Random traffic on depth 5 (pointer wrap, simultaneous push/pop)
    n_acc = 0; cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      cyc5(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      if (o5_acc) n_acc++;
      cyc++;
    end
    check("rand_nacc", 32'(n_acc), 32'd10000);
    for (int i = 0; i < 40 && q5.size() != 0; i++) cyc5(1'b0, 8'h00, 1'b1, 1'b0);
    check("rand_drained", 32'(q5.size()), 32'd0);
    cyc5(1'b0, 8'h00, 1'b1, 1'b0);
    check("rand_idle_level", 32'(o5_lv), 32'd0);

    // Flush with level 6 and a read in flight
    for (int i = 0; i < 6; i++) cyc16(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc16(1'b0, 8'h00, 1'b0, 1'b0);
    cyc16(1'b1, 8'h66, 1'b1, 1'b0);
    check("fl_pushpop_pop", 32'(o16_pop), 32'd1);
    cyc16(1'b0, 8'h00, 1'b0, 1'b0);
    check("fl_pre_level", 32'(o16_lv), 32'd6);
    cyc16(1'b1, 8'h77, 1'b1, 1'b1);
    check("fl_clr_level", 32'(o16_lv), 32'd6);
    cyc16(1'b0, 8'h00, 1'b0, 1'b0);
    check("fl_post_level", 32'(o16_lv), 32'd0);
    check("fl_post_mvalid", 32'(o16_mv), 32'd0);
    cyc16(1'b1, 8'h3C, 1'b1, 1'b0);
    cyc16(1'b0, 8'h00, 1'b1, 1'b0);
    check("fl_c1_mv", 32'(o16_mv), 32'd0);
    cyc16(1'b0, 8'h00, 1'b1, 1'b0);
    check("fl_c2_mv", 32'(o16_mv), 32'd0);
    cyc16(1'b0, 8'h00, 1'b1, 1'b0);
    check("fl_c3_mv", 32'(o16_mv), 32'd1);
    check("fl_c3_md", 32'(o16_md), 32'h3C);
    cyc16(1'b0, 8'h00, 1'b1, 1'b0);
    check("fl_end_level", 32'(o16_lv), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
